// File: rtl/seg_count_monitor.sv
// Receive-side monitor for an active-low 7-segment count display.
// Synchronizes SEG, filters transients, decodes digits, checks 0..MAX_DIGIT wrap.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   KEY       in   asynchronous active-low reset
//   SEG[6:0]  in   segment bus, bit 0 = a ... bit 6 = g, 0 = lit
//   LEDR[17:0] out [3:0] digit, [15:8] step tally, [17] sticky fault, others 0
//   LEDG[1:0] out  [0] digit valid, [1] one-cycle step pulse
module seg_count_monitor #(
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned MAX_DIGIT     = 7
) (
    input  logic        CLOCK_50,
    input  logic        KEY,
    input  logic [6:0]  SEG,
    output logic [17:0] LEDR,
    output logic [1:0]  LEDG
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        FAULT
    } state_t;

    localparam logic [15:0] STAB_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [3:0]  MAX_D     = 4'(MAX_DIGIT);

    // Internal pattern vectors hold segment a in the MSB so the
    // decode table below reads left-to-right as a..g.
    logic [6:0] seg_abc;
    logic [6:0] s1_q;
    logic [6:0] s2_q;
    logic [6:0] prev_q;

    logic [15:0] stab_cnt_q, stab_cnt_d;
    logic        accept;

    state_t      state_q, state_d;
    logic [3:0]  last_q, last_d;
    logic        valid_q, valid_d;
    logic        step_q, step_d;
    logic [7:0]  tally_q, tally_d;

    logic [3:0]  dec_dig;
    logic        dec_ok;
    logic        dec_blank;
    logic [3:0]  nxt;
    logic        legal;

    assign seg_abc = {SEG[0], SEG[1], SEG[2], SEG[3],
                      SEG[4], SEG[5], SEG[6]};

    // Synchronizer plus one-cycle-delayed copy used by the filter.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            s1_q   <= 7'b1111111;
            s2_q   <= 7'b1111111;
            prev_q <= 7'b1111111;
        end else begin
            s1_q   <= seg_abc;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // Counter saturates, so the equality test below fires only once
    // per stable episode.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (s2_q != prev_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != 16'hFFFF) begin
            stab_cnt_d = stab_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            stab_cnt_q <= '0;
        end else begin
            stab_cnt_q <= stab_cnt_d;
        end
    end

    assign accept = (stab_cnt_q == STAB_LAST);

    always_comb begin
        dec_dig   = '0;
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        unique case (prev_q)
            7'b0000001: dec_dig = 4'd0;
            7'b1001111: dec_dig = 4'd1;
            7'b0010010: dec_dig = 4'd2;
            7'b0000110: dec_dig = 4'd3;
            7'b1001100: dec_dig = 4'd4;
            7'b0100100: dec_dig = 4'd5;
            7'b0100000: dec_dig = 4'd6;
            7'b0001111: dec_dig = 4'd7;
            7'b0000000: dec_dig = 4'd8;
            7'b0000100: dec_dig = 4'd9;
            7'b1111111: begin
                dec_ok    = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    assign nxt = (last_q == MAX_D) ? 4'd0 : last_q + 4'd1;

    // Zero is always legal: the counter may be cleared at any point.
    assign legal = (dec_dig == 4'd0) ||
                   ((dec_dig <= MAX_D) && (dec_dig == nxt));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        tally_d = tally_q;
        if (accept && !dec_blank) begin
            if (!dec_ok) begin
                state_d = FAULT;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_d = TRACK;
                        last_d  = dec_dig;
                        valid_d = 1'b1;
                    end
                    TRACK: begin
                        if (dec_dig == last_q) begin
                            state_d = TRACK;
                        end else if (legal) begin
                            last_d  = dec_dig;
                            step_d  = 1'b1;
                            tally_d = tally_q + 8'd1;
                        end else begin
                            state_d = FAULT;
                            last_d  = dec_dig;
                        end
                    end
                    FAULT: begin
                        last_d  = dec_dig;
                        valid_d = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q <= IDLE;
            last_q  <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            tally_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            tally_q <= tally_d;
        end
    end

    assign LEDR = {(state_q == FAULT), 1'b0, tally_q, 4'b0000, last_q};
    assign LEDG = {step_q, valid_q};

endmodule

// File: tb/tb_seg_count_monitor.sv
// Bench for seg_count_monitor: directed vectors, queued expectations.
// A negedge monitor compares each output change against the queue.
module tb_seg_count_monitor;

    logic        clk;
    logic        KEY;
    logic [6:0]  SEG;
    logic [17:0] LEDR;
    logic [1:0]  LEDG;

    seg_count_monitor #(
        .STABLE_CYCLES(4),
        .MAX_DIGIT(7)
    ) dut (
        .CLOCK_50(clk),
        .KEY(KEY),
        .SEG(SEG),
        .LEDR(LEDR),
        .LEDG(LEDG)
    );

    typedef struct {
        logic [19:0] w;
        int          c;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [19:0] prev_w = '0;
    logic [6:0]  pat [0:9];

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] INV   = 7'b1010101;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] rev7(input logic [6:0] p);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = p[6-i];
        return r;
    endfunction

    // Monitor: every output change while out of reset must match
    // the head of the queue, in value and in cycle.
    initial begin : monitor
        logic [19:0] cur;
        logic [19:0] mon_prev;
        exp_t        e;
        mon_prev = '0;
        forever begin
            @(negedge clk);
            cur = {LEDR, LEDG};
            if (KEY && cur !== mon_prev) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got %h at cyc %0d, none expected",
                             cur, cyc);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.w || cyc != e.c) begin
                        n_bad++;
                        $display("FAIL out_change: got %h at cyc %0d, want %h at cyc %0d",
                                 cur, cyc, e.w, e.c);
                    end
                end
            end
            mon_prev = cur;
        end
    end

    // Drive one pattern for 'hold' cycles; queue the resulting
    // output change(s) expected 7 edges after the first sampling edge.
    task automatic apply(input logic [6:0] p, input int hold,
                         input logic [3:0] d, input logic v,
                         input logic s, input logic [7:0] t,
                         input logic f);
        logic [19:0] w;
        exp_t        e;
        w   = {f, 1'b0, t, 4'b0000, d, 1'b0, v};
        SEG = rev7(p);
        if (s) begin
            e.w = w | 20'h2;
            e.c = cyc + 7;
            q.push_back(e);
            e.w = w;
            e.c = cyc + 8;
            q.push_back(e);
        end else if (w != prev_w) begin
            e.w = w;
            e.c = cyc + 7;
            q.push_back(e);
        end
        prev_w = w;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        KEY = 1'b0;
        #1;
        n_cmp++;
        if ({LEDR, LEDG} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_clear: got LEDR=%h LEDG=%b, want 0/00",
                     LEDR, LEDG);
        end
        repeat (2) @(posedge clk);
        #1;
        KEY    = 1'b1;
        prev_w = '0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d expected changes never seen", tag, q.size());
        end
        n_cmp++;
        if ({LEDR, LEDG} !== prev_w) begin
            n_bad++;
            $display("FAIL %s_steady: got %h, want %h", tag, {LEDR, LEDG}, prev_w);
        end
    endtask

    initial begin
        pat[0] = 7'b0000001;
        pat[1] = 7'b1001111;
        pat[2] = 7'b0010010;
        pat[3] = 7'b0000110;
        pat[4] = 7'b1001100;
        pat[5] = 7'b0100100;
        pat[6] = 7'b0100000;
        pat[7] = 7'b0001111;
        pat[8] = 7'b0000000;
        pat[9] = 7'b0000100;
        KEY = 1'b1;
        SEG = rev7(BLANK);
        #2;
        do_reset();

        // Basic decode, legal run with wrap, glitch, clear, blank,
        // then out-of-sequence fault and tracking while faulted.
        apply(pat[0], 10, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int k = 1; k <= 7; k++)
            apply(pat[k], 10, 4'(k), 1'b1, 1'b1, 8'(k), 1'b0);
        apply(pat[0], 10, 4'd0, 1'b1, 1'b1, 8'd8, 1'b0);
        apply(pat[1], 10, 4'd1, 1'b1, 1'b1, 8'd9, 1'b0);
        apply(pat[2], 10, 4'd2, 1'b1, 1'b1, 8'd10, 1'b0);
        apply(pat[3], 10, 4'd3, 1'b1, 1'b1, 8'd11, 1'b0);
        apply(pat[2], 3,  4'd3, 1'b1, 1'b0, 8'd11, 1'b0);
        apply(pat[3], 10, 4'd3, 1'b1, 1'b0, 8'd11, 1'b0);
        apply(pat[4], 10, 4'd4, 1'b1, 1'b1, 8'd12, 1'b0);
        apply(pat[0], 10, 4'd0, 1'b1, 1'b1, 8'd13, 1'b0);
        apply(BLANK,  10, 4'd0, 1'b1, 1'b0, 8'd13, 1'b0);
        apply(pat[1], 10, 4'd1, 1'b1, 1'b1, 8'd14, 1'b0);
        apply(pat[2], 10, 4'd2, 1'b1, 1'b1, 8'd15, 1'b0);
        apply(pat[5], 10, 4'd5, 1'b1, 1'b0, 8'd15, 1'b1);
        apply(pat[6], 10, 4'd6, 1'b1, 1'b0, 8'd15, 1'b1);
        drain("seq");

        // Over-range digit after MAX.
        do_reset();
        apply(pat[7], 10, 4'd7, 1'b1, 1'b0, 8'd0, 1'b0);
        apply(pat[8], 10, 4'd8, 1'b1, 1'b0, 8'd0, 1'b1);
        drain("over");

        // Invalid pattern keeps the digit, then reset between edges.
        do_reset();
        apply(pat[3], 10, 4'd3, 1'b1, 1'b0, 8'd0, 1'b0);
        apply(INV,    8,  4'd3, 1'b1, 1'b0, 8'd0, 1'b1);
        drain("inv");
        @(negedge clk);
        #3;
        do_reset();

        // Reset mid-filter: pattern must be fully re-qualified.
        apply(pat[5], 5, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        do_reset();
        apply(pat[5], 10, 4'd5, 1'b1, 1'b0, 8'd0, 1'b0);
        drain("midfilt");

        // 256 legal steps: tally wraps to 0 without a fault.
        do_reset();
        apply(pat[0], 10, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int k = 1; k <= 256; k++)
            apply(pat[k % 8], 9, 4'(k % 8), 1'b1, 1'b1, 8'(k), 1'b0);
        drain("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
